// File: rtl/data_mem_mp_if.sv
// Load/read bus for data_mem_mp: scan load inputs plus packed multi-port read request/response.
// master = load/read requester, slave = memory.
interface data_mem_mp_if #(
  parameter int DATA_W    = 512,
  parameter int DEPTH     = 128,
  parameter int NUM_PORTS = 2
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                        scan_mode;
  logic                        scan_valid;
  logic [DATA_W-1:0]           scan_in;
  logic [NUM_PORTS*ADDR_W-1:0] addr_in;
  logic [NUM_PORTS-1:0]        package_valid_in;
  logic [NUM_PORTS*DATA_W-1:0] data_out;
  logic [NUM_PORTS*ADDR_W-1:0] addr_out;
  logic [NUM_PORTS-1:0]        package_valid_out;
  logic [ADDR_W:0]             word_count;
  logic                        load_done;
  logic                        overflow;
  logic [NUM_PORTS-1:0]        addr_err;

  modport master (
    output scan_mode, scan_valid, scan_in, addr_in, package_valid_in,
    input  data_out, addr_out, package_valid_out, word_count, load_done, overflow, addr_err
  );

  modport slave (
    input  scan_mode, scan_valid, scan_in, addr_in, package_valid_in,
    output data_out, addr_out, package_valid_out, word_count, load_done, overflow, addr_err
  );
endinterface

// File: rtl/data_mem_mp.sv
// data_mem_mp: scan-loaded word memory with NUM_PORTS conflict-free 1-cycle read ports, no backpressure.
// Macro DATA_MEM_ADDR_CHK_EN: out-of-range reads return zero data with addr_err; otherwise they wrap mod DEPTH.
module data_mem_mp #(
  parameter int DATA_W    = 512,
  parameter int DEPTH     = 128,
  parameter int NUM_PORTS = 2
) (
  input logic          clk,
  input logic          reset,
  data_mem_mp_if.slave bus
);
  localparam int              ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        w_enter_load;
  logic                        w_full;
  logic                        w_wr_en;
  logic [ADDR_W:0]             r_word_count;
  logic                        r_overflow;
  logic [DATA_W-1:0]           r_mem [DEPTH];
  logic [NUM_PORTS*DATA_W-1:0] r_data_out;
  logic [NUM_PORTS*ADDR_W-1:0] r_addr_out;
  logic [NUM_PORTS-1:0]        r_pvo;
  logic [NUM_PORTS-1:0]        w_rd_ok;
  logic [NUM_PORTS-1:0]        w_oor;
  logic [ADDR_W-1:0]           w_rd_idx [NUM_PORTS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_enter_load = 1'b0;
    case (r_state)
      S_IDLE, S_READY: begin
        if (bus.scan_mode) begin
          w_state_nxt  = S_LOAD;
          w_enter_load = 1'b1;
        end
      end
      S_LOAD:  if (!bus.scan_mode) w_state_nxt = S_READY;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_full  = (r_word_count == FULL);
  assign w_wr_en = (r_state == S_LOAD) && bus.scan_valid && !w_full;

  // word_count doubles as the write pointer: loaded words occupy 0..word_count-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word_count <= '0;
      r_overflow   <= 1'b0;
    end else if (w_enter_load) begin
      r_word_count <= '0;
      r_overflow   <= 1'b0;
    end else if ((r_state == S_LOAD) && bus.scan_valid) begin
      if (w_full) r_overflow   <= 1'b1;
      else        r_word_count <= r_word_count + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_word_count[ADDR_W-1:0]] <= bus.scan_in;
  end

  assign w_rd_ok = {NUM_PORTS{r_state == S_READY}} & bus.package_valid_in;

  // Address space is below 2*DEPTH, so a single subtract implements addr mod DEPTH.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [ADDR_W-1:0] w_addr;
    assign w_addr      = bus.addr_in[p*ADDR_W +: ADDR_W];
    assign w_oor[p]    = ({1'b0, w_addr} >= FULL);
    assign w_rd_idx[p] = w_oor[p] ? (w_addr - FULL[ADDR_W-1:0]) : w_addr;
  end

`ifdef DATA_MEM_ADDR_CHK_EN
  logic [NUM_PORTS-1:0] r_addr_err;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pvo      <= '0;
      r_data_out <= '0;
      r_addr_out <= '0;
`ifdef DATA_MEM_ADDR_CHK_EN
      r_addr_err <= '0;
`endif
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_pvo[p] <= w_rd_ok[p];
`ifdef DATA_MEM_ADDR_CHK_EN
        r_addr_err[p] <= w_rd_ok[p] && w_oor[p];
`endif
        if (w_rd_ok[p]) begin
          r_addr_out[p*ADDR_W +: ADDR_W] <= bus.addr_in[p*ADDR_W +: ADDR_W];
`ifdef DATA_MEM_ADDR_CHK_EN
          r_data_out[p*DATA_W +: DATA_W] <= w_oor[p] ? '0 : r_mem[w_rd_idx[p]];
`else
          r_data_out[p*DATA_W +: DATA_W] <= r_mem[w_rd_idx[p]];
`endif
        end
      end
    end
  end

  assign bus.data_out          = r_data_out;
  assign bus.addr_out          = r_addr_out;
  assign bus.package_valid_out = r_pvo;
  assign bus.word_count        = r_word_count;
  assign bus.load_done         = (r_state == S_READY);
  assign bus.overflow          = r_overflow;
`ifdef DATA_MEM_ADDR_CHK_EN
  assign bus.addr_err          = r_addr_err;
`else
  assign bus.addr_err          = '0;
`endif
endmodule

// File: tb/tb_data_mem_mp.sv
// Bench for data_mem_mp: directed load/read sequences, a read vector table, a DEPTH=100 range check,
// and randomized traffic scored against a behavioural memory model.
module tb_data_mem_mp;
  localparam int DW  = 512;
  localparam int DP  = 128;
  localparam int NP  = 2;
  localparam int AW  = 7;
  localparam int DW2 = 32;
  localparam int DP2 = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_mp_if #(.DATA_W(DW),  .DEPTH(DP),  .NUM_PORTS(NP)) bus ();
  data_mem_mp_if #(.DATA_W(DW2), .DEPTH(DP2), .NUM_PORTS(NP)) bus2 ();

  data_mem_mp #(.DATA_W(DW),  .DEPTH(DP),  .NUM_PORTS(NP)) u_dut    (.clk(clk), .reset(reset), .bus(bus));
  data_mem_mp #(.DATA_W(DW2), .DEPTH(DP2), .NUM_PORTS(NP)) u_dut100 (.clk(clk), .reset(reset), .bus(bus2));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural reference: memory array, saturating word counter, phase flags.
  logic [DW-1:0] m_mem [DP];
  int            m_cnt;
  bit            m_ovf, m_loading, m_ready;
  logic [DW-1:0] m_d   [NP];
  int            m_ao  [NP];
  bit [NP-1:0]   m_pvo;

  task automatic model_reset();
    m_cnt = 0; m_ovf = 0; m_loading = 0; m_ready = 0; m_pvo = '0;
    for (int p = 0; p < NP; p++) begin
      m_d[p]  = '0;
      m_ao[p] = 0;
    end
  endtask

  task automatic tick();
    int a;
    for (int p = 0; p < NP; p++) begin
      m_pvo[p] = m_ready && bus.package_valid_in[p];
      if (m_pvo[p]) begin
        a       = int'(bus.addr_in[p*AW +: AW]);
        m_d[p]  = m_mem[a];
        m_ao[p] = a;
      end
    end
    if (m_loading && bus.scan_valid) begin
      if (m_cnt < DP) begin
        m_mem[m_cnt] = bus.scan_in;
        m_cnt++;
      end else m_ovf = 1;
    end
    if (!m_loading && bus.scan_mode) begin
      m_loading = 1; m_ready = 0; m_cnt = 0; m_ovf = 0;
    end else if (m_loading && !bus.scan_mode) begin
      m_loading = 0; m_ready = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_wc"},   512'(bus.word_count),        512'(m_cnt));
    chk({tag, "_ld"},   512'(bus.load_done),         512'(m_ready));
    chk({tag, "_ovf"},  512'(bus.overflow),          512'(m_ovf));
    chk({tag, "_pvo"},  512'(bus.package_valid_out), 512'(m_pvo));
    chk({tag, "_aerr"}, 512'(bus.addr_err),          512'(0));
    for (int p = 0; p < NP; p++) begin
      chk({tag, "_dout"}, 512'(bus.data_out[p*DW +: DW]), 512'(m_d[p]));
      chk({tag, "_aout"}, 512'(bus.addr_out[p*AW +: AW]), 512'(m_ao[p]));
    end
  endtask

  task automatic set_rd(input int a0, input int a1, input logic [1:0] v);
    bus.addr_in          = {AW'(a1), AW'(a0)};
    bus.package_valid_in = v;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  typedef struct {
    int         a0;
    int         a1;
    logic [1:0] v;
    logic [1:0] pvo;
    int         d0;
    int         d1;
  } vec_t;

  vec_t          tbl [5];
  logic [DW-1:0] old40 [40];
  logic [DW-1:0] new10 [10];
  logic [DW-1:0] exp0, exp1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Memory words hold their own index, so data and addr_out expectations coincide.
    tbl[0] = '{5,  5,   2'b11, 2'b11, 5,  5};
    tbl[1] = '{0,  127, 2'b11, 2'b11, 0,  127};
    tbl[2] = '{64, 3,   2'b01, 2'b01, 64, 127};
    tbl[3] = '{9,  100, 2'b10, 2'b10, 64, 100};
    tbl[4] = '{1,  2,   2'b00, 2'b00, 64, 100};

    reset = 1'b1;
    bus.scan_mode = 0;  bus.scan_valid = 0;  bus.scan_in = '0;  bus.addr_in = '0;  bus.package_valid_in = '0;
    bus2.scan_mode = 0; bus2.scan_valid = 0; bus2.scan_in = '0; bus2.addr_in = '0; bus2.package_valid_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wc",    512'(bus.word_count),        512'(0));
    chk("rst_ld",    512'(bus.load_done),         512'(0));
    chk("rst_ovf",   512'(bus.overflow),          512'(0));
    chk("rst_pvo",   512'(bus.package_valid_out), 512'(0));
    chk("rst_aerr",  512'(bus.addr_err),          512'(0));
    chk("rst_dout1", 512'(bus.data_out[DW +: DW]), 512'(0));
    chk("rst_aout",  512'(bus.addr_out),          512'(0));
    chk("rst100_wc", 512'(bus2.word_count),       512'(0));
    reset = 1'b0;

    // scan_valid in IDLE is ignored
    bus.scan_valid = 1; bus.scan_in = rand_word();
    tick();
    chk("idle_sv_wc", 512'(bus.word_count), 512'(0));
    chk("idle_ld",    512'(bus.load_done),  512'(0));
    bus.scan_valid = 0;

    // full load of 128 words, word k = k
    bus.scan_mode = 1;
    tick();
    for (int k = 0; k < DP; k++) begin
      bus.scan_valid = 1; bus.scan_in = DW'(k);
      tick();
    end
    bus.scan_valid = 0; bus.scan_mode = 0;
    tick();
    chk("load_wc",  512'(bus.word_count), 512'(128));
    chk("load_ld",  512'(bus.load_done),  512'(1));
    chk("load_ovf", 512'(bus.overflow),   512'(0));

    for (int i = 0; i < 5; i++) begin
      set_rd(tbl[i].a0, tbl[i].a1, tbl[i].v);
      tick();
      chk($sformatf("tbl%0d_pvo", i),  512'(bus.package_valid_out), 512'(tbl[i].pvo));
      chk($sformatf("tbl%0d_d0", i),   512'(bus.data_out[0 +: DW]), 512'(tbl[i].d0));
      chk($sformatf("tbl%0d_d1", i),   512'(bus.data_out[DW +: DW]), 512'(tbl[i].d1));
      chk($sformatf("tbl%0d_a0", i),   512'(bus.addr_out[0 +: AW]), 512'(tbl[i].d0));
      chk($sformatf("tbl%0d_a1", i),   512'(bus.addr_out[AW +: AW]), 512'(tbl[i].d1));
      chk($sformatf("tbl%0d_aerr", i), 512'(bus.addr_err), 512'(0));
    end

    // reads issued on the READY->LOAD edge still complete from old contents
    set_rd(10, 20, 2'b11); bus.scan_mode = 1;
    tick();
    chk("flight_pvo", 512'(bus.package_valid_out), 512'(2'b11));
    chk("flight_d0",  512'(bus.data_out[0 +: DW]), 512'(10));
    chk("flight_d1",  512'(bus.data_out[DW +: DW]), 512'(20));
    chk("flight_ld",  512'(bus.load_done), 512'(0));
    // reads during LOAD are refused and outputs hold
    set_rd(7, 8, 2'b11);
    tick();
    chk("ldrd_pvo", 512'(bus.package_valid_out), 512'(0));
    chk("ldrd_d0",  512'(bus.data_out[0 +: DW]), 512'(10));
    chk("ldrd_d1",  512'(bus.data_out[DW +: DW]), 512'(20));
    chk("ldrd_a0",  512'(bus.addr_out[0 +: AW]), 512'(10));
    set_rd(0, 0, 2'b00);

    // overflow: 129th word dropped
    for (int k = 0; k < DP; k++) begin
      bus.scan_valid = 1; bus.scan_in = DW'(k);
      tick();
    end
    bus.scan_in = DW'(8'hFF);
    tick();
    chk("ovf_set", 512'(bus.overflow),   512'(1));
    chk("ovf_wc",  512'(bus.word_count), 512'(128));
    bus.scan_valid = 0; bus.scan_mode = 0;
    tick();
    set_rd(0, 127, 2'b11);
    tick();
    chk("ovf_d0",     512'(bus.data_out[0 +: DW]), 512'(0));
    chk("ovf_d127",   512'(bus.data_out[DW +: DW]), 512'(127));
    chk("ovf_sticky", 512'(bus.overflow), 512'(1));
    set_rd(0, 0, 2'b00);

    // asynchronous reset in the middle of a load
    bus.scan_mode = 1;
    tick();
    for (int k = 0; k < 40; k++) begin
      old40[k] = rand_word();
      bus.scan_valid = 1; bus.scan_in = old40[k];
      tick();
    end
    chk("pre_rst_wc", 512'(bus.word_count), 512'(40));
    #2 reset = 1'b1;
    #1;
    chk("arst_wc",  512'(bus.word_count),          512'(0));
    chk("arst_d1",  512'(bus.data_out[DW +: DW]),  512'(0));
    chk("arst_a1",  512'(bus.addr_out[AW +: AW]),  512'(0));
    chk("arst_pvo", 512'(bus.package_valid_out),   512'(0));
    chk("arst_ld",  512'(bus.load_done),           512'(0));
    bus.scan_valid = 0; bus.scan_mode = 0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst2_ovf", 512'(bus.overflow), 512'(0));

    bus.scan_mode = 1;
    tick();
    for (int k = 0; k < 10; k++) begin
      new10[k] = rand_word();
      bus.scan_valid = 1; bus.scan_in = new10[k];
      tick();
    end
    bus.scan_valid = 0; bus.scan_mode = 0;
    tick();
    chk("reload_wc", 512'(bus.word_count), 512'(10));
    for (int i = 0; i < 40; i += 2) begin
      set_rd(i, i + 1, 2'b11);
      tick();
      exp0 = (i < 10)     ? new10[i]     : old40[i];
      exp1 = (i + 1 < 10) ? new10[i + 1] : old40[i + 1];
      chk($sformatf("reread%0d", i),     512'(bus.data_out[0 +: DW]), 512'(exp0));
      chk($sformatf("reread%0d", i + 1), 512'(bus.data_out[DW +: DW]), 512'(exp1));
    end
    set_rd(0, 0, 2'b00);

    // DEPTH=100 instance: address 120 is out of range
    bus2.scan_mode = 1;
    tick();
    for (int k = 0; k < DP2; k++) begin
      bus2.scan_valid = 1; bus2.scan_in = DW2'(k * 3 + 1);
      tick();
    end
    bus2.scan_valid = 0; bus2.scan_mode = 0;
    tick();
    chk("d100_wc", 512'(bus2.word_count), 512'(100));
    bus2.addr_in = {7'd99, 7'd120}; bus2.package_valid_in = 2'b11;
    tick();
    bus2.package_valid_in = 2'b00;
    chk("d100_pvo", 512'(bus2.package_valid_out), 512'(2'b11));
    chk("d100_a0",  512'(bus2.addr_out[0 +: 7]), 512'(120));
    chk("d100_d1",  512'(bus2.data_out[DW2 +: DW2]), 512'(298));
`ifdef DATA_MEM_ADDR_CHK_EN
    chk("d100_aerr", 512'(bus2.addr_err), 512'(2'b01));
    chk("d100_d0",   512'(bus2.data_out[0 +: DW2]), 512'(0));
`else
    chk("d100_aerr", 512'(bus2.addr_err), 512'(2'b00));
    chk("d100_d0",   512'(bus2.data_out[0 +: DW2]), 512'(61));
`endif

    // randomized traffic against the reference model
    chk_model("pre_rnd");
    for (int n = 0; n < 400; n++) begin
      int a0, a1;
      if (n == 20 || n == 200 || $urandom_range(0, 149) == 0) bus.scan_mode = !bus.scan_mode;
      bus.scan_valid = ($urandom_range(0, 3) != 0);
      bus.scan_in    = rand_word();
      a0 = int'($urandom_range(0, DP - 1));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, DP - 1));
      set_rd(a0, a1, 2'($urandom_range(0, 3)));
      tick();
      chk_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
